// File: rtl/alu_seq_if.sv
// Handshake and result bus between the operand-read stage, the sequential
// ALU and writeback. The master issues operations and consumes results.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow, div_by_zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow, div_by_zero
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic/shift ops plus iterative
// MUL (shift-add, LSB first) and DIVU/REMU (restoring, MSB first), behind a
// valid/ready handshake with registered result and status flags.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;
  localparam logic [3:0] OP_PASSA = 4'd14;
  localparam logic [3:0] OP_PASSB = 4'd15;

  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  // Architectural state
  state_t           state_r,  state_n;
  logic [3:0]       op_r,     op_n;
  logic [WIDTH-1:0] a_r,      a_n;      // MUL: multiplier bits; DIV: dividend -> quotient
  logic [WIDTH-1:0] b_r,      b_n;      // MUL: shifted multiplicand; DIV: divisor
  logic [WIDTH-1:0] acc_r,    acc_n;    // MUL: partial product; DIV: partial remainder
  logic [SHW-1:0]   cnt_r,    cnt_n;
  logic [WIDTH-1:0] result_r, result_n;
  logic             zero_r,   zero_n;
  logic             carry_r,  carry_n;
  logic             ovf_r,    ovf_n;
  logic             dbz_r,    dbz_n;
  logic             out_valid_r, out_valid_n;

  // Single-cycle datapath
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_c_s;
  logic             alu_v_s;
  logic [SHW-1:0]   shamt_s;
  logic             is_multi_s;

  // Iterative datapath
  logic [WIDTH-1:0] mul_acc_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   trial_s;
  logic             sub_ok_s;
  logic [WIDTH-1:0] quot_s;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] fin_res_s;

  assign bus.in_ready    = (state_r == ST_IDLE) & ~rst;
  assign bus.out_valid   = out_valid_r;
  assign bus.result      = result_r;
  assign bus.zero        = zero_r;
  assign bus.carry       = carry_r;
  assign bus.overflow    = ovf_r;
  assign bus.div_by_zero = dbz_r;

  assign shamt_s    = bus.b[SHW-1:0];
  assign is_multi_s = (bus.op == OP_MUL) | (bus.op == OP_DIVU) | (bus.op == OP_REMU);

  // Single-cycle ALU evaluated on the live operands at the accept edge
  always_comb begin
    sum_s     = {1'b0, bus.a} + {1'b0, bus.b};
    diff_s    = {1'b0, bus.a} - {1'b0, bus.b};
    alu_res_s = '0;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                    (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s[WIDTH-1:0];
        alu_c_s   = ~diff_s[WIDTH];   // no borrow: a >= b unsigned
        alu_v_s   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                    (diff_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:   alu_res_s = bus.a & bus.b;
      OP_OR:    alu_res_s = bus.a | bus.b;
      OP_XOR:   alu_res_s = bus.a ^ bus.b;
      OP_NOR:   alu_res_s = ~(bus.a | bus.b);
      OP_SLT:   alu_res_s[0] = ($signed(bus.a) < $signed(bus.b));
      OP_SLTU:  alu_res_s[0] = (bus.a < bus.b);
      OP_SLL:   alu_res_s = bus.a << shamt_s;
      OP_SRL:   alu_res_s = bus.a >> shamt_s;
      OP_SRA:   alu_res_s = $signed(bus.a) >>> shamt_s;
      OP_PASSA: alu_res_s = bus.a;
      OP_PASSB: alu_res_s = bus.b;
      default:  alu_res_s = '0;        // multi-cycle ops do not use this path
    endcase
  end

  // One MUL / DIV iteration computed from the registered accumulators
  always_comb begin
    mul_acc_s = acc_r + (a_r[0] ? b_r : '0);
    rem_sh_s  = {acc_r, a_r[WIDTH-1]};
    trial_s   = rem_sh_s - {1'b0, b_r};
    sub_ok_s  = ~trial_s[WIDTH];
    quot_s    = {a_r[WIDTH-2:0], sub_ok_s};
    if (sub_ok_s) begin
      rem_s = trial_s[WIDTH-1:0];
    end else begin
      rem_s = rem_sh_s[WIDTH-1:0];
    end
    // A zero divisor always "fits", giving an all-ones quotient and a
    // remainder that shifts in all of a, so no special case is needed.
    case (op_r)
      OP_MUL:  fin_res_s = mul_acc_s;
      OP_DIVU: fin_res_s = quot_s;
      OP_REMU: fin_res_s = rem_s;
      default: fin_res_s = '0;
    endcase
  end

  // Next-state and next-register logic for the IDLE/BUSY/DONE sequencer
  always_comb begin
    state_n     = state_r;
    op_n        = op_r;
    a_n         = a_r;
    b_n         = b_r;
    acc_n       = acc_r;
    cnt_n       = cnt_r;
    result_n    = result_r;
    zero_n      = zero_r;
    carry_n     = carry_r;
    ovf_n       = ovf_r;
    dbz_n       = dbz_r;
    out_valid_n = out_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_n = bus.op;
          if (is_multi_s) begin
            a_n     = bus.a;
            b_n     = bus.b;
            acc_n   = '0;
            cnt_n   = '0;
            state_n = ST_BUSY;
          end else begin
            result_n    = alu_res_s;
            zero_n      = (alu_res_s == '0);
            carry_n     = alu_c_s;
            ovf_n       = alu_v_s;
            dbz_n       = 1'b0;
            out_valid_n = 1'b1;
            state_n     = ST_DONE;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (op_r == OP_MUL) begin
          acc_n = mul_acc_s;
          a_n   = a_r >> 1;
          b_n   = b_r << 1;
        end else begin
          acc_n = rem_s;
          a_n   = quot_s;
        end
        cnt_n = cnt_r + 1'b1;
        if (cnt_r == LAST_ITER) begin
          result_n    = fin_res_s;
          zero_n      = (fin_res_s == '0);
          carry_n     = 1'b0;
          ovf_n       = 1'b0;
          dbz_n       = (op_r != OP_MUL) && (b_r == '0);
          out_valid_n = 1'b1;
          state_n     = ST_DONE;
        end else begin
          state_n = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_n = 1'b0;
          state_n     = ST_IDLE;
        end else begin
          state_n = ST_DONE;
        end
      end
      default: begin
        out_valid_n = 1'b0;
        state_n     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      op_r        <= 4'd0;
      a_r         <= '0;
      b_r         <= '0;
      acc_r       <= '0;
      cnt_r       <= '0;
      result_r    <= '0;
      zero_r      <= 1'b0;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      dbz_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      op_r        <= op_n;
      a_r         <= a_n;
      b_r         <= b_n;
      acc_r       <= acc_n;
      cnt_r       <= cnt_n;
      result_r    <= result_n;
      zero_r      <= zero_n;
      carry_r     <= carry_n;
      ovf_r       <= ovf_n;
      dbz_r       <= dbz_n;
      out_valid_r <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with hand-computed expectations.
module tb_alu_seq;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // flags packed as {zero, carry, overflow, div_by_zero}
  logic [3:0] flg;
  assign flg = {bus.zero, bus.carry, bus.overflow, bus.div_by_zero};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge, scramble inputs afterwards, wait for out_valid.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op       = 4'd15;
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'h1234_5678;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic [3:0] exp_flg, input int exp_lat);
    int lat;
    run_op(op, a, b, lat);
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_res"}, bus.result, exp_res);
    check_eq({tag, "_flg"}, {28'd0, flg}, {28'd0, exp_flg});
  endtask

  initial begin
    int cyc;
    int ready_seen;
    int bad_hold;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 4'd0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_result", bus.result, 32'd0);
    check_eq("rst_flags", {28'd0, flg}, 32'd0);
    check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_in_ready_held", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready_rel", {31'd0, bus.in_ready}, 32'd1);

    // test 1: ADD overflow, latency 1
    do_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0010, 1);

    // test 2: shifts, compares, SUB and logic ops on a=0xC0000005 b=4
    do_op("sll",   4'd8,  32'hC000_0005, 32'h4, 32'h0000_0050, 4'b0000, 1);
    do_op("srl",   4'd9,  32'hC000_0005, 32'h4, 32'h0C00_0000, 4'b0000, 1);
    do_op("sra",   4'd10, 32'hC000_0005, 32'h4, 32'hFC00_0000, 4'b0000, 1);
    do_op("slt",   4'd6,  32'hC000_0005, 32'h4, 32'h0000_0001, 4'b0000, 1);
    do_op("sltu",  4'd7,  32'hC000_0005, 32'h4, 32'h0000_0000, 4'b1000, 1);
    do_op("sub",   4'd1,  32'hC000_0005, 32'h4, 32'hC000_0001, 4'b0100, 1);
    do_op("and",   4'd2,  32'hC000_0005, 32'h4, 32'h0000_0004, 4'b0000, 1);
    do_op("or",    4'd3,  32'hC000_0005, 32'h4, 32'hC000_0005, 4'b0000, 1);
    do_op("xor",   4'd4,  32'hC000_0005, 32'h4, 32'hC000_0001, 4'b0000, 1);
    do_op("nor",   4'd5,  32'hC000_0005, 32'h4, 32'h3FFF_FFFA, 4'b0000, 1);
    do_op("passa", 4'd14, 32'hC000_0005, 32'h4, 32'hC000_0005, 4'b0000, 1);
    do_op("passb", 4'd15, 32'hC000_0005, 32'h4, 32'h0000_0004, 4'b0000, 1);
    // upper shift-amount bits ignored: 0x21 -> shift by 1
    do_op("sll_mask", 4'd8, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 4'b0000, 1);
    // SUB with borrow: 1 - 2
    do_op("sub_borrow", 4'd1, 32'h1, 32'h2, 32'hFFFF_FFFF, 4'b0000, 1);

    // test 3: MUL with in_ready low throughout and an ignored pulse while busy
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 4'd11;
    bus.a        = 32'h0000_FFFF;
    bus.b        = 32'h0001_0001;
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 1;
    ready_seen = 0;
    while (bus.out_valid !== 1'b1 && cyc < 100) begin
      if (bus.in_ready === 1'b1) ready_seen++;
      if (cyc == 5) begin
        bus.in_valid = 1'b1;
        bus.op       = 4'd0;
        bus.a        = 32'd1;
        bus.b        = 32'd1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (bus.in_ready === 1'b1) ready_seen++;
    bus.in_valid = 1'b0;
    check_eq("mul_lat", cyc, 33);
    check_eq("mul_in_ready_busy", ready_seen, 0);
    check_eq("mul_res", bus.result, 32'hFFFF_FFFF);
    check_eq("mul_flg", {28'd0, flg}, 32'd0);
    @(negedge clk);
    check_eq("mul_no_ghost", {31'd0, bus.out_valid}, 32'd0);
    check_eq("mul_ready_after", {31'd0, bus.in_ready}, 32'd1);

    // test 5: backpressure on ADD 3 + (-3)
    bus.out_ready = 1'b0;
    do_op("bp_add", 4'd0, 32'd3, 32'hFFFF_FFFD, 32'd0, 4'b1100, 1);
    bad_hold = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.result !== 32'd0 || flg !== 4'b1100) bad_hold++;
    end
    check_eq("bp_hold", bad_hold, 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);

    // test 4: division and divide by zero (fixed latency)
    do_op("divu",    4'd12, 32'd100, 32'd7, 32'd14, 4'b0000, 33);
    do_op("remu",    4'd13, 32'd100, 32'd7, 32'd2,  4'b0000, 33);
    do_op("divu_z",  4'd12, 32'd5,   32'd0, 32'hFFFF_FFFF, 4'b0001, 33);
    do_op("remu_z",  4'd13, 32'd5,   32'd0, 32'd5,  4'b0001, 33);
    do_op("divu_ex", 4'd12, 32'd6,   32'd3, 32'd2,  4'b0000, 33);
    do_op("remu_ex", 4'd13, 32'd6,   32'd3, 32'd0,  4'b1000, 33);

    // test 6: async reset mid-MUL
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 4'd11;
    bus.a        = 32'd1234;
    bus.b        = 32'd5678;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("abort_busy", {31'd0, bus.in_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("abort_result", bus.result, 32'd0);
    check_eq("abort_flags", {28'd0, flg}, 32'd0);
    check_eq("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    do_op("post_abort_add", 4'd0, 32'd2, 32'd2, 32'd4, 4'b0000, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the 32-bit combinational ALU.
- Single-cycle logic, arithmetic and shift ops plus iterative multi-cycle MUL, DIVU and REMU, all behind a valid/ready interface.
- Registered result and status flags.
- Sits between the register-file read stage and writeback; it stalls upstream via in_ready while a multi-cycle op runs.

Parameters:
- WIDTH, 32: operand/result width; power of two, minimum 8.
- SHW, $clog2(WIDTH): shift-amount bits taken from b[SHW-1:0]; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and op are presented
- in_ready  output  1  block can accept; combinational: (state==IDLE) & ~rst
- op  input  4  operation select (encoding below)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result/flags valid; held until accepted
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- carry  output  1  carry-out (ADD) / no-borrow (SUB); 0 for other ops
- overflow  output  1  signed overflow for ADD/SUB; 0 otherwise
- div_by_zero  output  1  DIVU/REMU issued with b == 0; 0 otherwise

Behaviour:
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed, result 0/1), 7 SLTU
  - 8 SLL, 9 SRL, 10 SRA (shift a by b[SHW-1:0])
  - 11 MUL (low WIDTH bits of a*b), 12 DIVU, 13 REMU
  - 14 PASSA, 15 PASSB
- Reset (async, any state, including mid-operation): state=IDLE; result=0; all flags 0; out_valid=0; iteration counter and internal accumulators 0. Any in-flight op is discarded.
- Accept: an op is accepted on a rising edge with in_valid & in_ready. a, b and op are captured at that edge; later input changes are ignored.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, single-cycle op accepted: result and flags registered at the accept edge; go to DONE. out_valid=1 in the following cycle (latency 1).
  - IDLE, op 11/12/13 accepted: load accumulators, counter=0; go to BUSY.
  - BUSY: one iteration per cycle. MUL uses shift-add on a's bits (LSB first). DIVU/REMU use a restoring shift-subtract, MSB first. After WIDTH iterations (counter==WIDTH-1 at the edge), register result and flags; go to DONE. Latency from accept edge to out_valid = WIDTH+1 cycles.
  - DONE: out_valid=1; result and flags stable. On an edge with out_ready=1: out_valid drops and state goes to IDLE. The next op can be accepted no earlier than the following edge (no same-cycle turnaround).
- in_ready=0 in BUSY and DONE. in_valid in those states is ignored and not queued.
- Divide by zero: DIVU gives all ones; REMU gives a; div_by_zero=1. The full WIDTH cycles are still taken, so latency is fixed.
- SUB carry: 1 when a >= b unsigned.
- Overflow: set when the operands' signs agree (ADD) or differ (SUB) and the result sign differs from a.
- zero is computed on the final registered result for every op.
- Shift amounts use only b[SHW-1:0]; upper bits of b are ignored.
- out_ready may be held high continuously; the result is consumed in the first DONE cycle.

Test Plan:
1. WIDTH=32, ADD a=0x7FFFFFFF b=0x00000001 -> result=0x80000000, overflow=1, carry=0, zero=0; out_valid exactly 1 cycle after accept.
2. a=0xC0000005 b=0x00000004:
   - SLL -> 0x00000050
   - SRL -> 0x0C000000
   - SRA -> 0xFC000000
   - SLT -> 1, SLTU -> 0
   - SUB -> 0xC0000001, carry=1
3. MUL a=0x0000FFFF b=0x00010001 -> 0xFFFFFFFF. in_ready=0 for cycles 1..33 after accept; out_valid at cycle 33. A second in_valid pulse during BUSY is not accepted.
4. DIVU a=100 b=7 -> 14; REMU -> 2. DIVU a=5 b=0 -> 0xFFFFFFFF with div_by_zero=1; REMU a=5 b=0 -> 5 with div_by_zero=1.
5. Backpressure: ADD 3+(-3) with out_ready=0 for 5 cycles -> result=0, zero=1, carry=1, held stable with out_valid=1 and in_ready=0. Raise out_ready: out_valid=0 next cycle, in_ready=1.
6. Assert rst 10 cycles into a MUL -> result, flags and out_valid are 0 immediately (async). After deassert, in_ready=1. A new ADD 2+2 returns 4 with no trace of the aborted op.
